// File: rtl/ddr3_master_pkg.sv
// Shared types and constants for the DDR3 read master that drains buffer ranks into UDP bytes.
package ddr3_master_pkg;

    localparam int BYTES_PER_WORD = 16;
    localparam int DPB_ADDR_W     = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_H = 3'd1,
        FETCH_L = 3'd2,
        WAIT    = 3'd3,
        SEND    = 3'd4,
        DONE    = 3'd5
    } rd_state_e;

    // Bytes carried by a word: full width unless it is the last word with a short tail.
    function automatic logic [4:0] word_bytes(input logic is_last, input logic [5:0] bytecnt);
        if (is_last && bytecnt != 6'd0 && bytecnt < 6'(BYTES_PER_WORD))
            return bytecnt[4:0];
        return 5'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/ddr3_rd_byte_ser.sv
// Loads one 128-bit word and shifts it out MSB-first, one byte per accepted handshake.
module ddr3_rd_byte_ser (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] load_data,
    input  logic [4:0]   load_cnt,
    input  logic         ready,
    output logic [7:0]   data,
    output logic         de,
    output logic         word_last
);

    logic [127:0] shreg;
    logic [4:0]   left;

    // Handshake: a byte moves only on a cycle with de=1 and ready=1; while de=1 and
    // ready=0 the byte and its flags hold. de never drops without a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            left  <= '0;
        end else if (load) begin
            shreg <= load_data;
            left  <= load_cnt;
        end else if (de && ready) begin
            shreg <= {shreg[119:0], 8'h00};
            left  <= left - 5'd1;
        end
    end

    assign data      = shreg[127:120];
    assign de        = (left != 5'd0);
    assign word_last = (left == 5'd1);

endmodule

// File: rtl/ddr3_master_rd.sv
// Drains one DPB buffer rank (pairs of 64-bit reads per 128-bit word) into a byte stream.
module ddr3_master_rd
    import ddr3_master_pkg::*;
#(
    parameter logic [6:0] UDP_FRAME_MAX_SIZE_128 = 7'd91,
    parameter int         DPB_RD_LAT             = 2
) (
    input  logic                  i_pclk,
    input  logic                  i_rst,
    input  logic                  i_rd_req,
    input  logic [1:0]            i_rd_buf_rank,
    input  logic [7:0]            i_rd_buf_128cnt,
    input  logic [5:0]            i_rd_buf_Bytecnt,
    input  logic                  i_rd_frame_end,
    output logic                  o_rd_ack,
    output logic                  o_rd_busy,
    output logic                  o_rd_down,
    output logic                  o_dpb_rd_b_clk,
    output logic                  o_dpb_rd_b_cea,
    output logic                  o_dpb_rd_b_ocea,
    output logic [DPB_ADDR_W-1:0] o_dpb_rd_b_addr,
    input  logic [63:0]           i_dpb_rd_b_rd_data,
    output logic [7:0]            o_udp_data,
    output logic                  o_udp_de,
    input  logic                  i_udp_ready,
    output logic                  o_udp_last,
    output logic                  o_udp_frame_end,
    output logic [2:0]            dbg_state
);

    rd_state_e state, next_state;

    logic [1:0]            rank_q;
    logic [7:0]            cnt_q;
    logic [5:0]            bc_q;
    logic                  fe_q;
    logic [7:0]            widx;
    logic [63:0]           hi_q;
    logic [DPB_RD_LAT-1:0] pv_h, pv_l;
    logic [7:0]            cnt_clamp;
    logic                  last_word, xfer, word_done, hi_valid, lo_valid, ser_load;
    logic                  ser_de, ser_word_last;

    assign cnt_clamp = (i_rd_buf_128cnt > {1'b0, UDP_FRAME_MAX_SIZE_128}) ?
                       {1'b0, UDP_FRAME_MAX_SIZE_128} : i_rd_buf_128cnt;
    assign last_word = (widx == cnt_q - 8'd1);
    assign xfer      = ser_de && i_udp_ready;
    assign word_done = xfer && ser_word_last;
    assign hi_valid  = pv_h[DPB_RD_LAT-1];
    assign lo_valid  = pv_l[DPB_RD_LAT-1];

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_rd_req) next_state = (cnt_clamp == 8'd0) ? DONE : FETCH_H;
            FETCH_H: next_state = FETCH_L;
            FETCH_L: next_state = WAIT;
            WAIT:    if (lo_valid) next_state = SEND;
            SEND:    if (word_done) next_state = last_word ? DONE : FETCH_H;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_rd_ack        = 1'b0;
        o_rd_busy       = (state != IDLE);
        o_rd_down       = 1'b0;
        o_dpb_rd_b_cea  = 1'b0;
        o_dpb_rd_b_ocea = 1'b0;
        o_dpb_rd_b_addr = '0;
        ser_load        = 1'b0;
        case (state)
            IDLE:    o_rd_ack = i_rd_req;
            FETCH_H: begin
                o_dpb_rd_b_cea  = 1'b1;
                o_dpb_rd_b_addr = {rank_q, widx[6:0], 1'b0};
            end
            FETCH_L: begin
                o_dpb_rd_b_cea  = 1'b1;
                o_dpb_rd_b_ocea = 1'b1;
                o_dpb_rd_b_addr = {rank_q, widx[6:0], 1'b1};
            end
            WAIT: begin
                o_dpb_rd_b_ocea = 1'b1;
                ser_load        = lo_valid;
            end
            DONE:    o_rd_down = 1'b1;
            default: ;
        endcase
    end

    // pv_h/pv_l track each issued half-address until its data appears on the read port.
    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            rank_q <= '0;
            cnt_q  <= '0;
            bc_q   <= '0;
            fe_q   <= 1'b0;
            widx   <= '0;
            hi_q   <= '0;
            pv_h   <= '0;
            pv_l   <= '0;
        end else begin
            pv_h[0] <= (state == FETCH_H);
            pv_l[0] <= (state == FETCH_L);
            for (int i = 1; i < DPB_RD_LAT; i++) begin
                pv_h[i] <= pv_h[i-1];
                pv_l[i] <= pv_l[i-1];
            end
            if (hi_valid) hi_q <= i_dpb_rd_b_rd_data;
            if (state == IDLE && i_rd_req) begin
                rank_q <= i_rd_buf_rank;
                cnt_q  <= cnt_clamp;
                bc_q   <= i_rd_buf_Bytecnt;
                fe_q   <= i_rd_frame_end;
                widx   <= '0;
            end else if (state == SEND && word_done && !last_word) begin
                widx <= widx + 8'd1;
            end
        end
    end

    ddr3_rd_byte_ser u_ser (
        .clk       (i_pclk),
        .rst       (i_rst),
        .load      (ser_load),
        .load_data ({hi_q, i_dpb_rd_b_rd_data}),
        .load_cnt  (word_bytes(last_word, bc_q)),
        .ready     (i_udp_ready),
        .data      (o_udp_data),
        .de        (ser_de),
        .word_last (ser_word_last)
    );

    assign o_udp_de        = ser_de;
    assign o_udp_last      = ser_de && ser_word_last && last_word && (state == SEND);
    assign o_udp_frame_end = o_udp_last && fe_q;
    assign o_dpb_rd_b_clk  = i_pclk;
    assign dbg_state       = state;

endmodule

// File: tb/tb_ddr3_master_rd.sv
// Directed bench for ddr3_master_rd with a latency-2 DPB memory model and a byte monitor.
module tb_ddr3_master_rd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [1:0]  rd_rank = '0;
    logic [7:0]  rd_cnt = '0;
    logic [5:0]  rd_bc = '0;
    logic        rd_fe = 1'b0;
    logic        rd_ack, rd_busy, rd_down;
    logic        dpb_clk, dpb_cea, dpb_ocea;
    logic [9:0]  dpb_addr;
    logic [63:0] dpb_data;
    logic [7:0]  udp_data;
    logic        udp_de, udp_last, udp_fe;
    logic        udp_ready = 1'b0;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    ddr3_master_rd dut (
        .i_pclk(clk), .i_rst(rst), .i_rd_req(rd_req), .i_rd_buf_rank(rd_rank),
        .i_rd_buf_128cnt(rd_cnt), .i_rd_buf_Bytecnt(rd_bc), .i_rd_frame_end(rd_fe),
        .o_rd_ack(rd_ack), .o_rd_busy(rd_busy), .o_rd_down(rd_down),
        .o_dpb_rd_b_clk(dpb_clk), .o_dpb_rd_b_cea(dpb_cea), .o_dpb_rd_b_ocea(dpb_ocea),
        .o_dpb_rd_b_addr(dpb_addr), .i_dpb_rd_b_rd_data(dpb_data),
        .o_udp_data(udp_data), .o_udp_de(udp_de), .i_udp_ready(udp_ready),
        .o_udp_last(udp_last), .o_udp_frame_end(udp_fe), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] exp_byte(int rank, int w, int j);
        return 8'((w * 16 + j + rank * 37) & 255);
    endfunction

    function automatic logic [63:0] dpb_word(logic [9:0] a);
        logic [63:0] d;
        for (int i = 0; i < 8; i++)
            d[8*i +: 8] = exp_byte(int'(a[9:8]), int'(a[7:1]), int'(a[0]) * 8 + 7 - i);
        return d;
    endfunction

    // Memory model: data for an address appears two cycles after it is presented.
    logic [9:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        a1 <= dpb_addr;
        a2 <= a1;
    end
    assign dpb_data = dpb_word(a2);

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         got_last_q[$];
    bit         got_fe_q[$];
    logic [9:0] addr_q[$];
    int  cyc = 0, ack_cnt = 0, down_cnt = 0, de_cnt = 0;
    int  ack_cyc = 0, down_cyc = 0, first_de_cyc = -1, prev_de_cyc = -1, max_gap = 0;
    int  stab_err = 0;
    bit  wait_first = 0, bp_mode = 0, hold_prev = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        cyc++;
        if (!rst && hold_prev && !(udp_de && udp_data === prev_data && udp_last === prev_last))
            stab_err++;
        hold_prev = !rst && udp_de && !udp_ready;
        prev_data = udp_data;
        prev_last = udp_last;
        if (rd_ack) begin ack_cnt++; ack_cyc = cyc; wait_first = 1; end
        if (rd_down) begin down_cnt++; down_cyc = cyc; end
        if (dpb_cea) addr_q.push_back(dpb_addr);
        if (udp_de) begin
            de_cnt++;
            if (wait_first) begin first_de_cyc = cyc; wait_first = 0; end
            else if (prev_de_cyc >= 0 && cyc - prev_de_cyc > max_gap) max_gap = cyc - prev_de_cyc;
            prev_de_cyc = cyc;
        end
        if (udp_de && udp_ready) begin
            got_q.push_back(udp_data);
            got_last_q.push_back(udp_last);
            got_fe_q.push_back(udp_fe);
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) udp_ready = ($urandom_range(0, 99) < 30);
    end

    task automatic clear_mon();
        exp_q.delete(); got_q.delete(); got_last_q.delete(); got_fe_q.delete(); addr_q.delete();
        de_cnt = 0; max_gap = 0; prev_de_cyc = -1; first_de_cyc = -1; stab_err = 0;
    endtask

    task automatic build_exp(int rank, int cnt, int bc);
        int n, nb;
        n = (cnt > 91) ? 91 : cnt;
        for (int w = 0; w < n; w++) begin
            nb = (w == n - 1 && bc != 0 && bc < 16) ? bc : 16;
            for (int j = 0; j < nb; j++) exp_q.push_back(exp_byte(rank, w, j));
        end
    endtask

    task automatic start_req(logic [1:0] rank, logic [7:0] cnt, logic [5:0] bc, logic fe);
        int n0;
        bit seen = 0;
        @(posedge clk); #1;
        rd_req = 1; rd_rank = rank; rd_cnt = cnt; rd_bc = bc; rd_fe = fe;
        n0 = ack_cnt;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk); #1;
            if (ack_cnt != n0) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL ack_timeout: got no ack, required one"); end
        @(posedge clk); #1;
        rd_req = 0;
    endtask

    task automatic wait_down(int n0, int budget);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk); #1;
            if (down_cnt != n0) seen = 1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!seen) begin errors++; $display("FAIL down_timeout: got no o_rd_down, required one"); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_ack, rd_busy, rd_down, udp_de, udp_last, udp_fe, dpb_cea} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {rd_ack, rd_busy, rd_down, udp_de, udp_last, udp_fe, dpb_cea});
        end
        checks++;
        if (udp_data !== 8'h00 || dpb_addr !== 10'h000) begin
            errors++; $display("FAIL reset_data: data=%h addr=%h required 0/0", udp_data, dpb_addr);
        end
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++;
        if (rd_busy !== 1'b0 || dbg_state !== 3'd0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b state=%0d required 0/0", rd_busy, dbg_state);
        end
    endtask

    task automatic test_full_rank();
        int n0, bad = 0;
        clear_mon(); build_exp(0, 91, 0);
        udp_ready = 1; n0 = down_cnt;
        start_req(2'd0, 8'd91, 6'd0, 1'b0);
        wait_down(n0, 3000);
        checks++;
        if (got_q.size() != 1456) begin errors++; $display("FAIL full_count: got %0d required 1456", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 1455)) begin
                errors++; bad++;
                if (bad < 8) $display("FAIL full_byte[%0d]: got %h/%b required %h/%b", i, got_q[i], got_last_q[i], exp_q[i], i == 1455);
            end
        end
        checks++;
        if (down_cnt - n0 != 1) begin errors++; $display("FAIL full_down: got %0d pulses required 1", down_cnt - n0); end
        checks++;
        if (first_de_cyc - ack_cyc > 6) begin errors++; $display("FAIL first_latency: got %0d required <=6", first_de_cyc - ack_cyc); end
        checks++;
        if (max_gap > 5) begin errors++; $display("FAIL word_gap: got %0d required <=5", max_gap); end
    endtask

    task automatic test_partial();
        int n0;
        clear_mon(); build_exp(2, 3, 5);
        udp_ready = 1; n0 = down_cnt;
        start_req(2'd2, 8'd3, 6'd5, 1'b1);
        wait_down(n0, 200);
        checks++;
        if (got_q.size() != 37) begin errors++; $display("FAIL partial_count: got %0d required 37", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 36) || got_fe_q[i] !== (i == 36)) begin
                errors++;
                $display("FAIL partial_byte[%0d]: got %h/%b/%b required %h/%b/%b", i, got_q[i],
                         got_last_q[i], got_fe_q[i], exp_q[i], i == 36, i == 36);
            end
        end
    endtask

    task automatic test_backpressure();
        int n0;
        clear_mon(); build_exp(1, 4, 0);
        n0 = down_cnt; bp_mode = 1;
        start_req(2'd1, 8'd4, 6'd0, 1'b0);
        wait_down(n0, 3000);
        bp_mode = 0; udp_ready = 1;
        checks++;
        if (got_q.size() != 64) begin errors++; $display("FAIL bp_count: got %0d required 64", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled required 0", stab_err); end
    endtask

    task automatic test_clamp();
        int n0;
        clear_mon(); build_exp(3, 200, 0);
        udp_ready = 1; n0 = down_cnt;
        start_req(2'd3, 8'd200, 6'd0, 1'b0);
        wait_down(n0, 3000);
        checks++;
        if (got_q.size() != 1456) begin errors++; $display("FAIL clamp_count: got %0d required 1456", got_q.size()); end
        checks++;
        if (got_q.size() == 1456 && (got_q[1455] !== exp_q[1455] || got_last_q[1455] !== 1'b1)) begin
            errors++; $display("FAIL clamp_last: got %h/%b required %h/1", got_q[1455], got_last_q[1455], exp_q[1455]);
        end
    endtask

    task automatic test_empty();
        int n0, a0;
        clear_mon(); n0 = down_cnt; a0 = ack_cnt;
        start_req(2'd1, 8'd0, 6'd0, 1'b0);
        wait_down(n0, 20);
        checks++;
        if (ack_cnt - a0 != 1 || down_cnt - n0 != 1) begin
            errors++; $display("FAIL empty_pulses: ack=%0d down=%0d required 1/1", ack_cnt - a0, down_cnt - n0);
        end
        checks++;
        if (de_cnt != 0) begin errors++; $display("FAIL empty_de: got %0d de cycles required 0", de_cnt); end
    endtask

    task automatic test_reset_mid();
        int n0;
        bit hit = 0;
        clear_mon(); udp_ready = 1; n0 = down_cnt;
        start_req(2'd0, 8'd4, 6'd0, 1'b0);
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk); #1;
            if (got_q.size() >= 20) hit = 1;
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if (!hit || {rd_ack, rd_busy, rd_down, udp_de, udp_last, udp_fe, dpb_cea} !== 7'b0
            || udp_data !== 8'h00 || dpb_addr !== 10'h000) begin
            errors++;
            $display("FAIL mid_reset_outputs: hit=%b flags=%b data=%h addr=%h required 1/0/0/0", hit,
                     {rd_ack, rd_busy, rd_down, udp_de, udp_last, udp_fe, dpb_cea}, udp_data, dpb_addr);
        end
        @(posedge clk); #1 rst = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (down_cnt != n0) begin errors++; $display("FAIL mid_reset_down: got %0d pulses required 0", down_cnt - n0); end
        clear_mon(); build_exp(2, 2, 3);
        n0 = down_cnt;
        start_req(2'd2, 8'd2, 6'd3, 1'b0);
        wait_down(n0, 200);
        checks++;
        if (got_q.size() != 19) begin errors++; $display("FAIL after_reset_count: got %0d required 19", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL after_reset_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int n0, a0;
        bit seen = 0;
        logic [9:0] exp_addr[6];
        exp_addr = '{10'h000, 10'h001, 10'h100, 10'h101, 10'h102, 10'h103};
        clear_mon(); build_exp(0, 1, 0); build_exp(1, 2, 0);
        udp_ready = 1; n0 = down_cnt; a0 = ack_cnt;
        start_req(2'd0, 8'd1, 6'd0, 1'b0);
        @(posedge clk); #1;
        rd_req = 1; rd_rank = 2'd1; rd_cnt = 8'd2; rd_bc = 6'd0; rd_fe = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk); #1;
            if (ack_cnt - a0 == 2) seen = 1;
        end
        checks++;
        if (!seen || ack_cyc != down_cyc + 1) begin
            errors++; $display("FAIL b2b_accept: seen=%b ack at %0d required down+1=%0d", seen, ack_cyc, down_cyc + 1);
        end
        @(posedge clk); #1 rd_req = 0;
        wait_down(n0 + 1, 300);
        checks++;
        if (ack_cnt - a0 != 2 || down_cnt - n0 != 2) begin
            errors++; $display("FAIL b2b_pulses: ack=%0d down=%0d required 2/2", ack_cnt - a0, down_cnt - n0);
        end
        checks++;
        if (addr_q.size() != 6) begin errors++; $display("FAIL b2b_addr_count: got %0d required 6", addr_q.size()); end
        for (int i = 0; i < 6 && i < addr_q.size(); i++) begin
            checks++;
            if (addr_q[i] !== exp_addr[i]) begin errors++; $display("FAIL b2b_addr[%0d]: got %h required %h", i, addr_q[i], exp_addr[i]); end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_rank();
        test_partial();
        test_backpressure();
        test_clamp();
        test_empty();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
